// File: rtl/perceptron_pkg.sv
// Shared types and constants for the 2-input perceptron trainer.
// Weight limits here describe the default width; the core derives its own from W_WIDTH.
package perceptron_pkg;

    typedef enum logic {
        TRAIN = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int W_WIDTH_DEF = 8;

    typedef logic signed [W_WIDTH_DEF-1:0] weight_t;

    localparam weight_t WEIGHT_MAX = weight_t'((2 ** (W_WIDTH_DEF - 1)) - 1);
    localparam weight_t WEIGHT_MIN = weight_t'(-(2 ** (W_WIDTH_DEF - 1)));

endpackage : perceptron_pkg

// File: rtl/perceptron_neuron.sv
// Combinational neuron: weighted sum of two binary inputs plus bias, and a step output.
// The sum is two bits wider than the operands so it can never overflow.
module perceptron_neuron #(
    parameter int W_WIDTH = 8
) (
    input  logic                      x0,
    input  logic                      x1,
    input  logic signed [W_WIDTH-1:0] w0,
    input  logic signed [W_WIDTH-1:0] w1,
    input  logic signed [W_WIDTH-1:0] bias,
    output logic signed [W_WIDTH+1:0] sum,
    output logic                      y
);

    always_comb begin
        // NOTE: blocking assignments in combinational logic; each line sees the previous partial sum.
        sum = {{2{bias[W_WIDTH-1]}}, bias};
        if (x0) begin
            sum = sum + {{2{w0[W_WIDTH-1]}}, w0};
        end
        if (x1) begin
            sum = sum + {{2{w1[W_WIDTH-1]}}, w1};
        end
        // Strictly positive: sign bit clear and not zero.
        y = !sum[W_WIDTH+1] && (sum != '0);
    end

endmodule : perceptron_neuron

// File: rtl/perceptron_top_core.sv
// Perceptron trainer: walks the 4-entry truth table one sample per clock, applying the
// perceptron rule with saturating updates until an error-free epoch or the epoch limit.
module perceptron_top_core
    import perceptron_pkg::*;
#(
    parameter int          W_WIDTH    = W_WIDTH_DEF,
    parameter logic [3:0]  TARGET_FN  = 4'b1000,
    parameter int          MAX_EPOCHS = 32
) (
    input  logic clk_i,
    input  logic reset_i
);

    localparam logic signed [W_WIDTH-1:0] SAT_MAX    = {1'b0, {(W_WIDTH-1){1'b1}}};
    localparam logic signed [W_WIDTH-1:0] SAT_MIN    = {1'b1, {(W_WIDTH-1){1'b0}}};
    localparam logic signed [W_WIDTH-1:0] ONE        = {{(W_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [5:0]                LAST_EPOCH = 6'(MAX_EPOCHS - 1);

    state_t                     state_q,     state_d;
    logic [1:0]                 sample_q,    sample_d;
    logic [5:0]                 epoch_q,     epoch_d;
    logic [2:0]                 err_cnt_q,   err_cnt_d;
    logic signed [W_WIDTH-1:0]  w0_q,        w0_d;
    logic signed [W_WIDTH-1:0]  w1_q,        w1_d;
    logic signed [W_WIDTH-1:0]  bias_q,      bias_d;
    logic                       done_q,      done_d;
    logic                       converged_q, converged_d;

    logic                       x0;
    logic                       x1;
    logic                       target;
    logic                       y;
    logic                       err_pos;
    logic                       err_neg;
    logic                       err_any;
    logic [2:0]                 err_total;
    // The raw sum is only observed hierarchically; the update rule needs just y.
    logic signed [W_WIDTH+1:0]  sum_unused;

    assign x0     = sample_q[0];
    assign x1     = sample_q[1];
    assign target = TARGET_FN[sample_q];

    perceptron_neuron #(
        .W_WIDTH (W_WIDTH)
    ) u_neuron (
        .x0   (x0),
        .x1   (x1),
        .w0   (w0_q),
        .w1   (w1_q),
        .bias (bias_q),
        .sum  (sum_unused),
        .y    (y)
    );

    // err = target - y: +1 when the neuron under-fires, -1 when it over-fires.
    assign err_pos   = target & ~y;
    assign err_neg   = ~target & y;
    assign err_any   = err_pos | err_neg;
    assign err_total = err_cnt_q + {2'b00, err_any};

    // Add +1/-1/0 to a weight, clamping at the signed range limits.
    function automatic logic signed [W_WIDTH-1:0] sat_step(
        input logic signed [W_WIDTH-1:0] v,
        input logic                      up,
        input logic                      dn
    );
        if (up && (v != SAT_MAX)) begin
            return v + ONE;
        end
        if (dn && (v != SAT_MIN)) begin
            return v - ONE;
        end
        return v;
    endfunction

    always_comb begin
        // NOTE: every output gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        sample_d    = sample_q;
        epoch_d     = epoch_q;
        err_cnt_d   = err_cnt_q;
        w0_d        = w0_q;
        w1_d        = w1_q;
        bias_d      = bias_q;
        done_d      = done_q;
        converged_d = converged_q;

        case (state_q)
            TRAIN: begin
                w0_d      = sat_step(w0_q, err_pos & x0, err_neg & x0);
                w1_d      = sat_step(w1_q, err_pos & x1, err_neg & x1);
                bias_d    = sat_step(bias_q, err_pos, err_neg);
                err_cnt_d = err_total;
                sample_d  = sample_q + 2'd1;

                if (sample_q == 2'd3) begin
                    if (err_total == 3'd0) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        converged_d = 1'b1;
                    end else if (epoch_q == LAST_EPOCH) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        converged_d = 1'b0;
                    end else begin
                        epoch_d   = epoch_q + 6'd1;
                        err_cnt_d = 3'd0;
                    end
                end
            end
            DONE: begin
                // Results are frozen until the next reset.
            end
            default: begin
                state_d = TRAIN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            state_q     <= TRAIN;
            sample_q    <= '0;
            epoch_q     <= '0;
            err_cnt_q   <= '0;
            w0_q        <= '0;
            w1_q        <= '0;
            bias_q      <= '0;
            done_q      <= 1'b0;
            converged_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            epoch_q     <= epoch_d;
            err_cnt_q   <= err_cnt_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            bias_q      <= bias_d;
            done_q      <= done_d;
            converged_q <= converged_d;
        end
    end

endmodule : perceptron_top_core

// File: tb/tb_perceptron_top_core.sv
// Scoreboard bench for perceptron_top_core: AND, OR and XOR trainers run side by side,
// expected register snapshots are queued per clock edge and compared by a negedge monitor.
module tb_perceptron_top_core;
    import perceptron_pkg::*;

    typedef struct {
        int state;
        int sample;
        int epoch;
        int err;
        int w0;
        int w1;
        int bias;
        int done;
        int conv;
    } snap_t;

    typedef struct {
        int    cyc;
        int    dut;
        string tag;
        int    mask;
        snap_t exp;
    } exp_t;

    localparam int M_STATE  = 1;
    localparam int M_SAMPLE = 2;
    localparam int M_EPOCH  = 4;
    localparam int M_ERR    = 8;
    localparam int M_W      = 16;
    localparam int M_FLAGS  = 32;
    localparam int M_ALL    = 63;

    localparam int D_AND = 0;
    localparam int D_OR  = 1;
    localparam int D_XOR = 2;

    logic clk = 1'b0;
    logic reset_and = 1'b1;
    logic reset_or  = 1'b1;
    logic reset_xor = 1'b1;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    perceptron_top_core #(.W_WIDTH(8), .TARGET_FN(4'b1000), .MAX_EPOCHS(32)) dut_and (
        .clk_i   (clk),
        .reset_i (reset_and)
    );
    perceptron_top_core #(.W_WIDTH(8), .TARGET_FN(4'b1110), .MAX_EPOCHS(32)) dut_or (
        .clk_i   (clk),
        .reset_i (reset_or)
    );
    perceptron_top_core #(.W_WIDTH(8), .TARGET_FN(4'b0110), .MAX_EPOCHS(32)) dut_xor (
        .clk_i   (clk),
        .reset_i (reset_xor)
    );

    function automatic snap_t mk(int st, int smp, int ep, int er, int a, int b, int c, int dn, int cv);
        snap_t s;
        s.state = st; s.sample = smp; s.epoch = ep; s.err = er;
        s.w0 = a; s.w1 = b; s.bias = c; s.done = dn; s.conv = cv;
        return s;
    endfunction

    function automatic snap_t probe(int d);
        snap_t s;
        s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        case (d)
            D_AND: begin
                s.state = (dut_and.state_q == DONE) ? 1 : 0;
                s.sample = int'(dut_and.sample_q); s.epoch = int'(dut_and.epoch_q);
                s.err = int'(dut_and.err_cnt_q);
                s.w0 = int'(dut_and.w0_q); s.w1 = int'(dut_and.w1_q); s.bias = int'(dut_and.bias_q);
                s.done = int'(dut_and.done_q); s.conv = int'(dut_and.converged_q);
            end
            D_OR: begin
                s.state = (dut_or.state_q == DONE) ? 1 : 0;
                s.sample = int'(dut_or.sample_q); s.epoch = int'(dut_or.epoch_q);
                s.err = int'(dut_or.err_cnt_q);
                s.w0 = int'(dut_or.w0_q); s.w1 = int'(dut_or.w1_q); s.bias = int'(dut_or.bias_q);
                s.done = int'(dut_or.done_q); s.conv = int'(dut_or.converged_q);
            end
            default: begin
                s.state = (dut_xor.state_q == DONE) ? 1 : 0;
                s.sample = int'(dut_xor.sample_q); s.epoch = int'(dut_xor.epoch_q);
                s.err = int'(dut_xor.err_cnt_q);
                s.w0 = int'(dut_xor.w0_q); s.w1 = int'(dut_xor.w1_q); s.bias = int'(dut_xor.bias_q);
                s.done = int'(dut_xor.done_q); s.conv = int'(dut_xor.converged_q);
            end
        endcase
        return s;
    endfunction

    task automatic check(input string tag, input string field, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s.%s actual=%0d required=%0d (cycle %0d)", tag, field, act, req, cyc);
        end
    endtask

    task automatic compare(input exp_t e);
        snap_t a;
        a = probe(e.dut);
        if ((e.mask & M_STATE)  != 0) check(e.tag, "state",     a.state,  e.exp.state);
        if ((e.mask & M_SAMPLE) != 0) check(e.tag, "sample_q",  a.sample, e.exp.sample);
        if ((e.mask & M_EPOCH)  != 0) check(e.tag, "epoch_q",   a.epoch,  e.exp.epoch);
        if ((e.mask & M_ERR)    != 0) check(e.tag, "err_cnt_q", a.err,    e.exp.err);
        if ((e.mask & M_W) != 0) begin
            check(e.tag, "w0_q",   a.w0,   e.exp.w0);
            check(e.tag, "w1_q",   a.w1,   e.exp.w1);
            check(e.tag, "bias_q", a.bias, e.exp.bias);
        end
        if ((e.mask & M_FLAGS) != 0) begin
            check(e.tag, "done_q",      a.done, e.exp.done);
            check(e.tag, "converged_q", a.conv, e.exp.conv);
        end
    endtask

    task automatic push(input int d, input int at, input string tag, input int mask, input snap_t e);
        exp_t x;
        x.cyc = at; x.dut = d; x.tag = tag; x.mask = mask; x.exp = e;
        sb.push_back(x);
    endtask

    // Monitor: compares every queued expectation whose edge has just occurred.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                compare(sb[i]);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s expired actual=cycle %0d required=cycle %0d", sb[i].tag, cyc, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    initial begin
        snap_t zero, and4, and5, and10, and23, and_fin;
        snap_t or15, or_fin, xor127, xor_fin;
        int base, b2, b3;

        zero    = mk(0, 0, 0, 0, 0, 0,  0, 0, 0);
        and4    = mk(0, 0, 1, 0, 1, 1,  1, 0, 0);
        and5    = mk(0, 1, 1, 1, 1, 1,  0, 0, 0);
        and10   = mk(0, 2, 2, 1, 0, 2, -1, 0, 0);
        and23   = mk(0, 3, 5, 0, 1, 2, -2, 0, 0);
        and_fin = mk(1, 0, 5, 0, 1, 2, -2, 1, 1);
        or15    = mk(0, 3, 3, 0, 1, 1,  0, 0, 0);
        or_fin  = mk(1, 0, 3, 0, 1, 1,  0, 1, 1);
        xor127  = mk(0, 3, 31, 0, 0, 0, 0, 0, 0);
        xor_fin = mk(1, 0, 31, 0, 0, 0, 0, 1, 0);

        // One reset edge for all three trainers, then release together.
        @(posedge clk); #1;
        base = cyc;
        reset_and = 1'b0;
        reset_or  = 1'b0;
        reset_xor = 1'b0;

        push(D_AND, base, "and_reset", M_ALL, zero);
        push(D_OR,  base, "or_reset",  M_ALL, zero);
        push(D_XOR, base, "xor_reset", M_ALL, zero);

        push(D_AND, base + 4,  "and_e4",  M_STATE | M_SAMPLE | M_EPOCH | M_W, and4);
        push(D_AND, base + 5,  "and_e5",  M_ALL, and5);
        push(D_AND, base + 10, "and_e10", M_ALL, and10);
        push(D_AND, base + 23, "and_e23", M_ALL, and23);
        push(D_AND, base + 24, "and_e24", M_ALL, and_fin);
        for (int k = 25; k <= 44; k++) begin
            push(D_AND, base + k, "and_hold", M_ALL, and_fin);
        end

        push(D_OR, base + 15, "or_e15", M_ALL, or15);
        push(D_OR, base + 16, "or_e16", M_ALL, or_fin);

        push(D_XOR, base + 127, "xor_e127", M_STATE | M_SAMPLE | M_EPOCH | M_FLAGS, xor127);
        push(D_XOR, base + 128, "xor_e128", M_STATE | M_SAMPLE | M_EPOCH | M_FLAGS, xor_fin);

        repeat (44) @(posedge clk);
        #1;

        // Fresh AND run, interrupted by a reset after edge 10.
        reset_and = 1'b1;
        @(posedge clk); #1;
        reset_and = 1'b0;
        b2 = cyc;
        push(D_AND, b2,      "and2_reset",  M_ALL, zero);
        push(D_AND, b2 + 10, "and2_e10",    M_ALL, and10);
        push(D_AND, b2 + 11, "and2_midrst", M_ALL, zero);
        repeat (10) @(posedge clk);
        #1;
        reset_and = 1'b1;
        @(posedge clk); #1;
        reset_and = 1'b0;

        // Retraining must reproduce the first run exactly.
        b3 = cyc;
        push(D_AND, b3 + 4,  "and3_e4",  M_STATE | M_SAMPLE | M_EPOCH | M_W, and4);
        push(D_AND, b3 + 5,  "and3_e5",  M_ALL, and5);
        push(D_AND, b3 + 10, "and3_e10", M_ALL, and10);
        push(D_AND, b3 + 23, "and3_e23", M_ALL, and23);
        push(D_AND, b3 + 24, "and3_e24", M_ALL, and_fin);
        push(D_AND, b3 + 30, "and3_hold", M_ALL, and_fin);
        repeat (30) @(posedge clk);
        #1;

        if (cyc < base + 130) begin
            repeat (base + 130 - cyc) @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;

        while (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s never_compared actual=cycle %0d required=cycle %0d", sb[0].tag, cyc, sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_perceptron_top_core
